signal_cfg_writer: RTL and testbench

- Write-side counterpart of the per-channel signal configuration bus.
- Software writes 32-bit words into an 832-bit shadow register through a valid/ready write port.
- A commit request copies the shadow to the live cfg_data bus, but only at a waveform period boundary (sync_tick), so all fields of a channel change in the same cycle.
- One instance sits between the register bus bridge and each channel's configuration slicer.

---
 rtl/signal_cfg_writer.sv | 132 +++++++++++++
 tb/tb_signal_cfg_writer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_cfg_writer.sv
// Shadow/live configuration register: 32-bit writes build an 832-bit shadow,
// and commits copy it to cfg_data on a period boundary. Optional readback: SIGNAL_CFG_WRITER_READBACK_EN.
module signal_cfg_writer #(
  parameter int NUM_WORDS  = 26,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              wr_strb,
  output logic                    wr_err,
  input  logic                    commit_req,
  input  logic                    sync_tick,
  input  logic                    commit_force,
  output logic                    commit_busy,
  output logic                    commit_done,
  output logic [1:0]              dbg_state,
  output logic [32*NUM_WORDS-1:0] cfg_data
`ifdef SIGNAL_CFG_WRITER_READBACK_EN
  ,
  input  logic                    rd_valid,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    rd_sel,
  output logic [31:0]             rd_data,
  output logic                    rd_data_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [32*NUM_WORDS-1:0] shadow_flat;
  logic [NUM_WORDS-1:0]    word_hit;
  logic                    wr_fire;
  logic                    addr_oob;

  // Write handshake: a beat transfers on any rising edge where wr_valid && wr_ready;
  // the master holds wr_addr/wr_data/wr_strb stable while wr_valid is high and wr_ready low.
  assign wr_fire   = wr_valid && wr_ready;
  assign addr_oob  = (word_hit == '0);
  assign dbg_state = state;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state  <= IDLE;
      wr_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_err <= wr_fire && addr_oob;
    end
  end

  always_comb begin
    state_nxt   = state;
    commit_busy = 1'b0;
    commit_done = 1'b0;
    wr_ready    = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = !reset;
        // A tick arriving with the request is not used; the next one applies.
        if (commit_req) state_nxt = PENDING;
      end
      PENDING: begin
        commit_busy = 1'b1;
        if (sync_tick || commit_force) state_nxt = APPLY;
      end
      APPLY: begin
        commit_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    // Upper halves of words 17, 19, 23 and 25 are reserved and never stored.
    localparam logic [31:0] KEEP = (k == 17 || k == 19 || k == 23 || k == 25) ?
                                   32'h0000_FFFF : 32'hFFFF_FFFF;
    logic [31:0] shadow_q;
    logic [31:0] live_q;

    assign word_hit[k] = (wr_addr == ADDR_WIDTH'(k));

    always_ff @(posedge aclk) begin
      if (reset) begin
        shadow_q <= '0;
        live_q   <= '0;
      end else begin
        if (wr_fire && word_hit[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) shadow_q[8*b +: 8] <= wr_data[8*b +: 8] & KEEP[8*b +: 8];
          end
        end
        if (state == APPLY) live_q <= shadow_q;
      end
    end

    assign shadow_flat[32*k +: 32] = shadow_q;
    assign cfg_data[32*k +: 32]    = live_q;
  end

`ifdef SIGNAL_CFG_WRITER_READBACK_EN
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (rd_addr == ADDR_WIDTH'(k)) rd_word = rd_sel ? cfg_data[32*k +: 32] : shadow_flat[32*k +: 32];
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_valid;
      if (rd_valid) rd_data <= rd_word;
    end
  end
`endif

endmodule

// File: tb/tb_signal_cfg_writer.sv
// Directed bench for signal_cfg_writer: a monitor scores every commit and wr_err pulse
// against queues of hand-computed expectations pushed by the stimulus.
module tb_signal_cfg_writer;
  localparam int NW = 26;
  localparam int AW = 5;
  localparam int CW = 32 * NW;

  logic          aclk;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          wr_err;
  logic          commit_req;
  logic          sync_tick;
  logic          commit_force;
  logic          commit_busy;
  logic          commit_done;
  logic [1:0]    dbg_state;
  logic [CW-1:0] cfg_data;
`ifdef SIGNAL_CFG_WRITER_READBACK_EN
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_sel;
  logic [31:0]   rd_data;
  logic          rd_data_valid;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [CW-1:0] exp_q[$];
  logic [AW-1:0] err_q[$];

  signal_cfg_writer #(.NUM_WORDS(NW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
    .commit_req(commit_req), .sync_tick(sync_tick), .commit_force(commit_force),
    .commit_busy(commit_busy), .commit_done(commit_done),
    .dbg_state(dbg_state), .cfg_data(cfg_data)
`ifdef SIGNAL_CFG_WRITER_READBACK_EN
    , .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid)
`endif
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(negedge aclk);
    while (!wr_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!wr_ready) check("write accept timeout", {31'd0, wr_ready}, 1);
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_req();
    commit_req = 1'b1;
    step(1);
    commit_req = 1'b0;
  endtask

  task automatic tick_commit(input string name);
    sync_tick = 1'b1;
    step(1);
    sync_tick = 1'b0;
    @(negedge aclk);
    check({name, " done latency"}, {831'd0, commit_done}, 1);
    step(1);
    @(negedge aclk);
    check({name, " busy clear"}, {831'd0, commit_busy}, 0);
    step(1);
  endtask

  // scoreboard monitor
  logic [CW-1:0] prev_cfg;
  logic          rst_prev = 1'b1;
  logic          cmp_pending = 1'b0;

  always @(negedge aclk) begin
    if (cmp_pending) begin
      cmp_pending = 1'b0;
      check("cfg after commit", cfg_data, exp_q.pop_front());
    end else if (!rst_prev && !reset && cfg_data !== prev_cfg) begin
      check("cfg held outside commit", cfg_data, prev_cfg);
    end
    if (commit_done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected commit_done", 1, 0);
      else cmp_pending = 1'b1;
    end
    if (wr_err === 1'b1) begin
      if (err_q.size() == 0) check("unexpected wr_err", 1, 0);
      else begin
        void'(err_q.pop_front());
        n_total++;
        n_pass++;
      end
    end
    prev_cfg = cfg_data;
    rst_prev = reset;
  end

  logic [CW-1:0] exp1, exp2, exp4;

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    commit_req = 1'b0; sync_tick = 1'b0; commit_force = 1'b0;
`ifdef SIGNAL_CFG_WRITER_READBACK_EN
    rd_valid = 1'b0; rd_addr = '0; rd_sel = 1'b0;
`endif
    exp1 = '0;
    exp1[31:0]  = 32'h1122_3344;
    exp1[63:32] = 32'h0000_CCDD;
    exp2 = exp1;
    exp2[63:32]       = 32'h00EE_CCDD;
    exp2[32*17 +: 32] = 32'h0000_FFFF;
    exp2[32*19 +: 32] = 32'h0000_0000;
    exp2[32*23 +: 32] = 32'h0000_A5A5;
    exp2[32*25 +: 32] = 32'h0000_5600;
    exp4 = exp2;
    exp4[32*4 +: 32]  = 32'h5566_7788;

    // reset state
    step(3);
    @(negedge aclk);
    check("reset wr_ready", {831'd0, wr_ready}, 0);
    check("reset cfg_data", cfg_data, '0);
    check("reset commit_busy", {831'd0, commit_busy}, 0);
    check("reset commit_done", {831'd0, commit_done}, 0);
    check("reset wr_err", {831'd0, wr_err}, 0);
    step(1);
    reset = 1'b0;
    @(negedge aclk);
    check("wr_ready after reset", {831'd0, wr_ready}, 1);
    check("state after reset", {830'd0, dbg_state}, 0);
    step(1);

    // basic write + commit on sync_tick
    do_write(5'd0, 32'h1122_3344, 4'hF);
    do_write(5'd1, 32'hAABB_CCDD, 4'h3);
    pulse_req();
    step(3);
    @(negedge aclk);
    check("cfg before tick", cfg_data, '0);
    check("busy while pending", {831'd0, commit_busy}, 1);
    check("ready while pending", {831'd0, wr_ready}, 0);
    step(1);
    exp_q.push_back(exp1);
    tick_commit("commit1");

    // out-of-range, zero strobe, partial strobes, reserved bits
    err_q.push_back(5'd26);
    do_write(5'd26, 32'hFFFF_FFFF, 4'hF);
    do_write(5'd2, 32'hDEAD_BEEF, 4'h0);
    do_write(5'd1, 32'hFFEE_DDCC, 4'b0100);
    do_write(5'd17, 32'hFFFF_FFFF, 4'hF);
    do_write(5'd19, 32'hFFFF_FFFF, 4'b1100);
    do_write(5'd23, 32'hA5A5_A5A5, 4'hF);
    // write accepted in the same cycle as commit_req
    wr_valid = 1'b1; wr_addr = 5'd25; wr_data = 32'h1234_5678; wr_strb = 4'b1010;
    commit_req = 1'b1;
    step(1);
    wr_valid = 1'b0; commit_req = 1'b0;
    exp_q.push_back(exp2);
    step(2);
    tick_commit("commit2");

    // write stalls during PENDING and lands after commit_done
    pulse_req();
    exp_q.push_back(exp2);
    wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 32'h5566_7788; wr_strb = 4'hF;
    step(2);
    @(negedge aclk);
    check("stall ready", {831'd0, wr_ready}, 0);
    step(1);
    sync_tick = 1'b1;
    step(1);
    sync_tick = 1'b0;
    @(negedge aclk);
    check("stall done", {831'd0, commit_done}, 1);
    check("ready in apply", {831'd0, wr_ready}, 0);
    step(1);
    @(negedge aclk);
    check("ready after done", {831'd0, wr_ready}, 1);
    step(1);
    wr_valid = 1'b0;
    step(2);

    // req with tick ignored, repeated req, then commit_force
    commit_req = 1'b1; sync_tick = 1'b1;
    step(1);
    commit_req = 1'b0; sync_tick = 1'b0;
    step(2);
    @(negedge aclk);
    check("tick with req ignored", {831'd0, commit_busy}, 1);
    step(1);
    pulse_req();
    exp_q.push_back(exp4);
    commit_force = 1'b1;
    step(1);
    commit_force = 1'b0;
    @(negedge aclk);
    check("force done", {831'd0, commit_done}, 1);
    check("cfg before force apply", cfg_data, exp2);
    step(5);

    // reset while PENDING
    do_write(5'd5, 32'h1234_5678, 4'hF);
    pulse_req();
    step(2);
    reset = 1'b1;
    step(1);
    @(negedge aclk);
    check("reset mid cfg", cfg_data, '0);
    check("reset mid busy", {831'd0, commit_busy}, 0);
    step(1);
    reset = 1'b0;
    sync_tick = 1'b1;
    step(1);
    sync_tick = 1'b0;
    step(4);
    @(negedge aclk);
    check("cfg after reset tick", cfg_data, '0);
    step(1);
    pulse_req();
    exp_q.push_back('0);
    tick_commit("commit zero shadow");

`ifdef SIGNAL_CFG_WRITER_READBACK_EN
    do_write(5'd3, 32'h0000_BEEF, 4'hF);
    rd_valid = 1'b1; rd_addr = 5'd3; rd_sel = 1'b0;
    step(1);
    rd_valid = 1'b0;
    @(negedge aclk);
    check("read shadow", {800'd0, rd_data}, 32'h0000_BEEF);
    check("read valid", {831'd0, rd_data_valid}, 1);
    step(1);
    rd_valid = 1'b1; rd_sel = 1'b1;
    step(1);
    rd_valid = 1'b0;
    @(negedge aclk);
    check("read live", {800'd0, rd_data}, 0);
    step(1);
    rd_valid = 1'b1; rd_addr = 5'd30; rd_sel = 1'b0;
    step(1);
    rd_valid = 1'b0;
    @(negedge aclk);
    check("read out of range", {800'd0, rd_data}, 0);
    step(1);
`endif

    step(4);
    check("commit queue drained", CW'(exp_q.size()), 0);
    check("err queue drained", CW'(err_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
